// File: rtl/frame_mode_scheduler.sv
// rtl/frame_mode_scheduler.sv - frame-boundary commit of stage enables, balance update scheduling, video timeout
// Optional macro FRAME_SCHED_VSYNC_SYNC_EN: 2-flop vsync synchronizer ahead of edge detection.
module frame_mode_scheduler #(
   parameter int FRAME_PERIOD = 8,
   parameter int TIMEOUT_CYC  = 2_000_000,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             vsync,
   input  logic             gamma_evt,
   input  logic             wb_evt,
   input  logic             gray_evt,
   input  logic             face_evt,
   input  logic             wb_req,
   output logic             gamma_en,
   output logic             wb_en,
   output logic             gray_en,
   output logic             face_en,
   output logic             balance_update,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             no_signal
);
   localparam int              TC_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TC_W-1:0] TC_MAX  = TC_W'(TIMEOUT_CYC);
   localparam logic [7:0]      FP_LAST = 8'(FRAME_PERIOD - 1);

   typedef enum logic [1:0] {U_OFF, U_SETTLE, U_RUN} upd_state_t;

   logic vsync_s;
`ifdef FRAME_SCHED_VSYNC_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], vsync};
   end
   assign vsync_s = sync_q[1];
`else
   assign vsync_s = vsync;
`endif

   logic             vsync_d_q;
   logic             fs;
   logic             fs_upd;
   logic [3:0]       evt;
   logic [3:0]       en_q, en_d;
   logic [3:0]       pend_q, pend_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [TC_W-1:0]  tcnt_q, tcnt_d;
   upd_state_t       state_q;
   logic [7:0]       fcnt_q;
   logic             req_q;
   logic             bu_q;

   assign evt       = {face_evt, gray_evt, wb_evt, gamma_evt};
   assign fs        = vsync_s & ~vsync_d_q;
   assign no_signal = (tcnt_q == TC_MAX);
   // The fs that ends a timeout carries no valid frame statistics.
   assign fs_upd    = fs & ~no_signal;

   always_comb begin
      en_d        = en_q;
      pend_d      = pend_q ^ evt;
      frame_cnt_d = frame_cnt_q;
      tcnt_d      = tcnt_q;
      if (no_signal) begin
         en_d   = en_q ^ evt;
         pend_d = 4'b0000;
      end else if (fs) begin
         en_d   = en_q ^ pend_q;
         pend_d = evt;
      end
      if (fs) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
         tcnt_d      = '0;
      end else if (tcnt_q != TC_MAX) begin
         tcnt_d = tcnt_q + TC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vsync_d_q   <= 1'b0;
         en_q        <= 4'b0000;
         pend_q      <= 4'b0000;
         frame_cnt_q <= '0;
         tcnt_q      <= '0;
      end else begin
         vsync_d_q   <= vsync_s;
         en_q        <= en_d;
         pend_q      <= pend_d;
         frame_cnt_q <= frame_cnt_d;
         tcnt_q      <= tcnt_d;
      end
   end

   // Driven by the enable being committed, so the disabling fs never pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= U_OFF;
         fcnt_q  <= 8'd0;
         req_q   <= 1'b0;
         bu_q    <= 1'b0;
      end else begin
         bu_q <= 1'b0;
         if (!en_d[1]) begin
            state_q <= U_OFF;
            fcnt_q  <= 8'd0;
            req_q   <= 1'b0;
         end else begin
            case (state_q)
               U_OFF: state_q <= U_SETTLE;
               U_SETTLE: begin
                  req_q <= req_q | wb_req;
                  if (fs_upd) begin
                     bu_q    <= 1'b1;
                     fcnt_q  <= 8'd0;
                     req_q   <= wb_req;
                     state_q <= U_RUN;
                  end
               end
               U_RUN: begin
                  req_q <= req_q | wb_req;
                  if (fs_upd) begin
                     req_q <= wb_req;
                     if (req_q || fcnt_q == FP_LAST) begin
                        bu_q   <= 1'b1;
                        fcnt_q <= 8'd0;
                     end else begin
                        fcnt_q <= fcnt_q + 8'd1;
                     end
                  end
               end
               default: state_q <= U_OFF;
            endcase
         end
      end
   end

   assign gamma_en       = en_q[0];
   assign wb_en          = en_q[1];
   assign gray_en        = en_q[2];
   assign face_en        = en_q[3];
   assign balance_update = bu_q;
   assign frame_cnt      = frame_cnt_q;
endmodule

// File: tb/tb_frame_mode_scheduler.sv
// tb/tb_frame_mode_scheduler.sv - randomized bench for frame_mode_scheduler against a frame-level reference model
module tb_frame_mode_scheduler;
   localparam int FP = 8;
   localparam int TO = 1000;
   localparam int CW = 4;

   logic          clk;
   logic          rstn;
   logic          vsync;
   logic          gamma_evt, wb_evt, gray_evt, face_evt, wb_req;
   logic          gamma_en, wb_en, gray_en, face_en, balance_update, no_signal;
   logic [CW-1:0] frame_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int bu_seen  = 0;

   logic [3:0] m_en;
   int         m_par [4];
   int         m_fc;
   int         m_since;
   logic       m_vs_prev;
   logic [1:0] m_pipe;
   logic       m_active, m_first, m_req, m_bu;
   int         m_frames;

   frame_mode_scheduler #(.FRAME_PERIOD(FP), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .vsync(vsync),
      .gamma_evt(gamma_evt), .wb_evt(wb_evt), .gray_evt(gray_evt), .face_evt(face_evt),
      .wb_req(wb_req),
      .gamma_en(gamma_en), .wb_en(wb_en), .gray_en(gray_en), .face_en(face_en),
      .balance_update(balance_update), .frame_cnt(frame_cnt), .no_signal(no_signal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic rnd(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   task automatic model_reset();
      m_en = 4'b0000;
      for (int i = 0; i < 4; i++) m_par[i] = 0;
      m_fc = 0; m_since = 0; m_vs_prev = 1'b0; m_pipe = 2'b00;
      m_active = 1'b0; m_first = 1'b0; m_req = 1'b0; m_bu = 1'b0; m_frames = 0;
   endtask

   // One clock of the reference: events are counted per frame and their parity decides the toggle.
   task automatic model_step(input logic vs, input logic [3:0] ev, input logic rq);
      logic v, fsv, ns, was_active;
`ifdef FRAME_SCHED_VSYNC_SYNC_EN
      v = m_pipe[1];
      m_pipe = {m_pipe[0], vs};
`else
      v = vs;
`endif
      fsv = v && !m_vs_prev;
      m_vs_prev = v;
      ns = (m_since >= TO);
      for (int i = 0; i < 4; i++) begin
         if (ns) begin
            if (ev[i]) m_en[i] = !m_en[i];
            m_par[i] = 0;
         end else if (fsv) begin
            if (m_par[i] % 2 == 1) m_en[i] = !m_en[i];
            m_par[i] = int'(ev[i]);
         end else begin
            m_par[i] += int'(ev[i]);
         end
      end
      if (fsv) m_fc = (m_fc + 1) % (1 << CW);
      m_since = fsv ? 0 : m_since + 1;
      was_active = m_active;
      m_bu = 1'b0;
      if (!m_en[1]) begin
         m_active = 1'b0; m_first = 1'b0; m_frames = 0; m_req = 1'b0;
      end else if (!was_active) begin
         m_active = 1'b1; m_first = 1'b1;
      end else if (fsv && !ns) begin
         if (m_first || m_req || m_frames + 1 == FP) begin
            m_bu = 1'b1; m_frames = 0; m_first = 1'b0;
         end else begin
            m_frames++;
         end
         m_req = rq;
      end else begin
         m_req = m_req || rq;
      end
   endtask

   task automatic check_outputs();
      check_eq("gamma_en", 32'(gamma_en), 32'(m_en[0]));
      check_eq("wb_en", 32'(wb_en), 32'(m_en[1]));
      check_eq("gray_en", 32'(gray_en), 32'(m_en[2]));
      check_eq("face_en", 32'(face_en), 32'(m_en[3]));
      check_eq("balance_update", 32'(balance_update), 32'(m_bu));
      check_eq("frame_cnt", 32'(frame_cnt), 32'(m_fc));
      check_eq("no_signal", 32'(no_signal), 32'(m_since >= TO));
   endtask

   task automatic cycle(input logic vs, input logic [3:0] ev, input logic rq);
      check_outputs();
      if (balance_update) bu_seen++;
      vsync = vs;
      {face_evt, gray_evt, wb_evt, gamma_evt} = ev;
      wb_req = rq;
      model_step(vs, ev, rq);
      @(negedge clk);
   endtask

   task automatic run_frame(input int len, input int p_ev, input int p_wb, input int p_rq,
                            input logic [3:0] rise_ev, input int rq_at);
      logic [3:0] ev;
      for (int k = 0; k < len; k++) begin
         ev = {rnd(p_ev), rnd(p_ev), rnd(p_wb), rnd(p_ev)};
         if (k == 0) ev = ev | rise_ev;
         cycle(k < 4, ev, rnd(p_rq) || (k == rq_at));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, 32'({face_en, gray_en, wb_en, gamma_en, balance_update, no_signal}), 32'd0);
      check_eq({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
   endtask

   initial begin
      rstn = 1'b0; vsync = 1'b0; wb_req = 1'b0;
      {face_evt, gray_evt, wb_evt, gamma_evt} = 4'b0000;
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      rstn = 1'b1;

      repeat (10) cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0001, 1'b0);
      repeat (89) cycle(1'b0, 4'b0000, 1'b0);
      repeat (4) cycle(1'b1, 4'b0000, 1'b0);
      repeat (20) cycle(1'b0, 4'b0000, 1'b0);
      check_eq("gamma_en_first_frame", 32'(gamma_en), 32'd1);
      check_eq("frame_cnt_first_frame", 32'(frame_cnt), 32'd1);

      cycle(1'b0, 4'b0100, 1'b0);
      repeat (5) cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0100, 1'b0);
      run_frame(40, 0, 0, 0, 4'b0000, -1);
      check_eq("gray_double_cancel", 32'(gray_en), 32'd0);
      run_frame(40, 0, 0, 0, 4'b0100, -1);
      run_frame(40, 0, 0, 0, 4'b0000, -1);

      cycle(1'b0, 4'b0010, 1'b0);
      repeat (5) cycle(1'b0, 4'b0000, 1'b0);
      bu_seen = 0;
      repeat (20) run_frame(40, 0, 0, 0, 4'b0000, -1);
      check_eq("bu_pulses_20_frames", 32'(bu_seen), 32'd3);
      run_frame(40, 0, 0, 0, 4'b0000, 20);
      repeat (10) run_frame(40, 0, 0, 0, 4'b0000, -1);
      cycle(1'b0, 4'b0010, 1'b0);
      bu_seen = 0;
      repeat (6) run_frame(40, 0, 0, 20, 4'b0000, -1);
      check_eq("bu_none_when_off", 32'(bu_seen), 32'd0);

      repeat (30) run_frame(int'($urandom_range(20, 60)), 3, 2, 5, 4'b0000, -1);

      for (int k = 0; k < 1100; k++) cycle(1'b0, {rnd(1), rnd(1), rnd(1), rnd(1)}, rnd(2));
      check_eq("no_signal_set", 32'(no_signal), 32'd1);
      cycle(1'b0, 4'b1000, 1'b0);
      repeat (3) run_frame(40, 2, 2, 5, 4'b0000, -1);
      check_eq("no_signal_clear", 32'(no_signal), 32'd0);

      repeat (12) run_frame(int'($urandom_range(20, 50)), 4, 3, 5, 4'b0000, -1);
      for (int k = 0; k < 15; k++) cycle(k < 4, {rnd(10), rnd(10), rnd(10), rnd(10)}, rnd(10));
      vsync = 1'b0; wb_req = 1'b0;
      {face_evt, gray_evt, wb_evt, gamma_evt} = 4'b0000;
      rstn = 1'b0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      run_frame(40, 0, 0, 0, 4'b0000, -1);
      check_eq("frame_cnt_after_reset", 32'(frame_cnt), 32'd1);
      check_eq("en_after_reset", 32'({face_en, gray_en, wb_en, gamma_en}), 32'd0);
      repeat (8) run_frame(int'($urandom_range(20, 50)), 4, 3, 5, 4'b0000, -1);
      check_outputs();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
